// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and data access.
// Data has priority, but a streak limit guarantees fetch a grant while both are pending.
module mem_port_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT     = 256,
  parameter int DSTREAK_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_ready,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_err,
  input  logic                  d_req,
  input  logic                  d_rw,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic                  d_ready,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [DATA_W/8-1:0]   bus_be,
  input  logic                  bus_ack,
  input  logic [DATA_W-1:0]     bus_rdata,
  output logic                  busy
);

  localparam int BE_W = DATA_W / 8;
  localparam int TW   = $clog2(TIMEOUT);
  localparam int SW   = $clog2(DSTREAK_MAX + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] S_MAX  = SW'(DSTREAK_MAX);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state, state_nx;
  logic                owner_d, owner_d_nx;
  logic [SW-1:0]       streak, streak_nx;
  logic [TW-1:0]       tcnt, tcnt_nx;
  logic                bus_req_nx, bus_we_nx, busy_nx;
  logic [ADDR_W-1:0]   bus_addr_nx;
  logic [DATA_W-1:0]   bus_wdata_nx;
  logic [BE_W-1:0]     bus_be_nx;
  logic                if_ready_nx, if_err_nx, d_ready_nx, d_err_nx;
  logic [DATA_W-1:0]   if_rdata_nx, d_rdata_nx, cap_rdata;

  // Writes never return data, even if the bus drives something on ack
  assign cap_rdata = bus_we ? '0 : bus_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      streak    <= '0;
      tcnt      <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
      if_ready  <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      d_ready   <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      owner_d   <= owner_d_nx;
      streak    <= streak_nx;
      tcnt      <= tcnt_nx;
      bus_req   <= bus_req_nx;
      bus_we    <= bus_we_nx;
      bus_addr  <= bus_addr_nx;
      bus_wdata <= bus_wdata_nx;
      bus_be    <= bus_be_nx;
      if_ready  <= if_ready_nx;
      if_err    <= if_err_nx;
      if_rdata  <= if_rdata_nx;
      d_ready   <= d_ready_nx;
      d_err     <= d_err_nx;
      d_rdata   <= d_rdata_nx;
      busy      <= busy_nx;
    end
  end

  // Response outputs default to 0 so they only live for the single RESP cycle
  always_comb begin
    state_nx     = state;
    owner_d_nx   = owner_d;
    streak_nx    = streak;
    tcnt_nx      = tcnt;
    bus_req_nx   = bus_req;
    bus_we_nx    = bus_we;
    bus_addr_nx  = bus_addr;
    bus_wdata_nx = bus_wdata;
    bus_be_nx    = bus_be;
    if_ready_nx  = 1'b0;
    if_err_nx    = 1'b0;
    if_rdata_nx  = '0;
    d_ready_nx   = 1'b0;
    d_err_nx     = 1'b0;
    d_rdata_nx   = '0;

    case (state)
      IDLE: begin
        if (d_req && (!if_req || streak < S_MAX)) begin
          owner_d_nx = 1'b1;
          streak_nx  = if_req ? streak + 1'b1 : '0;
          if (d_rw && d_be == '0) begin
            state_nx   = RESP;
            d_ready_nx = 1'b1;
          end else begin
            state_nx     = BUSY;
            tcnt_nx      = '0;
            bus_req_nx   = 1'b1;
            bus_we_nx    = d_rw;
            bus_addr_nx  = d_addr;
            bus_wdata_nx = d_rw ? d_wdata : '0;
            bus_be_nx    = d_rw ? d_be : '1;
          end
        end else if (if_req) begin
          owner_d_nx   = 1'b0;
          streak_nx    = '0;
          state_nx     = BUSY;
          tcnt_nx      = '0;
          bus_req_nx   = 1'b1;
          bus_we_nx    = 1'b0;
          bus_addr_nx  = if_addr;
          bus_wdata_nx = '0;
          bus_be_nx    = '1;
        end
      end
      BUSY: begin
        // Ack is checked first so it wins over a coincident timeout
        if (bus_ack) begin
          bus_req_nx = 1'b0;
          state_nx   = RESP;
          if (owner_d) begin
            d_ready_nx = 1'b1;
            d_rdata_nx = cap_rdata;
          end else begin
            if_ready_nx = 1'b1;
            if_rdata_nx = cap_rdata;
          end
        end else if (tcnt == T_LAST) begin
          bus_req_nx = 1'b0;
          state_nx   = RESP;
          if (owner_d) begin
            d_ready_nx = 1'b1;
            d_err_nx   = 1'b1;
          end else begin
            if_ready_nx = 1'b1;
            if_err_nx   = 1'b1;
          end
        end else begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

endmodule
